// File: rtl/lsu_data_memory.sv
// RV32 load/store data memory with byte lanes, sign/zero extension, a fixed
// read latency behind a request/response handshake, and error reporting.
module lsu_data_memory #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // a response transfers on a rising edge where rsp_valid && rsp_ready, and the
  // response payload is held stable while rsp_valid is high and rsp_ready is low.

  localparam int AW = $clog2(DEPTH);
  localparam int CW = 4;
  localparam logic [CW-1:0] LAT_M1 = CW'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic           req_ready_q;
  logic           rsp_valid_q;
  logic           rsp_err_q;
  logic [31:0]    rsp_rdata_q;
  logic [31:0]    mem_q [DEPTH];

  logic           accept;
  logic [AW-1:0]  word_idx;
  logic           f3_illegal;
  logic           misaligned;
  logic           out_of_range;
  logic           req_err;
  logic [31:0]    rd_word;
  logic [7:0]     ld_byte;
  logic [15:0]    ld_half;
  logic [31:0]    load_data;
  logic [31:0]    rdata_d;
  logic [3:0]     byte_en;
  logic [31:0]    wr_data;

  assign accept   = req_valid && req_ready_q;
  assign word_idx = req_addr[AW+1:2];
  // Upper address bits are only range-checked, so aliases never wrap onto storage.
  assign out_of_range = |req_addr[31:AW+2];

  always_comb begin
    f3_illegal = 1'b0;
    if (req_we) begin
      f3_illegal = req_funct3[2] || (req_funct3[1:0] == 2'b11);
    end else begin
      f3_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
    end
  end

  assign misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign req_err    = f3_illegal || misaligned || out_of_range;

  assign rd_word = mem_q[word_idx];
  assign ld_half = req_addr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    ld_byte = rd_word[7:0];
    case (req_addr[1:0])
      2'd0:    ld_byte = rd_word[7:0];
      2'd1:    ld_byte = rd_word[15:8];
      2'd2:    ld_byte = rd_word[23:16];
      default: ld_byte = rd_word[31:24];
    endcase
  end

  always_comb begin
    load_data = '0;
    case (req_funct3)
      3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b010:  load_data = rd_word;
      3'b100:  load_data = {24'd0, ld_byte};
      3'b101:  load_data = {16'd0, ld_half};
      default: load_data = '0;
    endcase
  end

  // Stores and failed requests always answer with zero data.
  assign rdata_d = (req_we || req_err) ? '0 : load_data;

  always_comb begin
    byte_en = 4'b0000;
    wr_data = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        byte_en = 4'b0001 << req_addr[1:0];
        wr_data = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        byte_en = req_addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        byte_en = 4'b1111;
        wr_data = req_wdata;
      end
      default: begin
        byte_en = 4'b0000;
        wr_data = req_wdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept && req_we && !req_err) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem_q[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            rsp_rdata_q <= rdata_d;
            rsp_err_q   <= req_err;
            req_ready_q <= 1'b0;
            if (LATENCY == 1) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= LAT_M1;
            end
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_lsu_data_memory.sv
// Bench for lsu_data_memory: three instances (LATENCY 1, 3, 4) checked against a
// byte-level memory model every cycle, plus directed vectors with literal results.
module tb_lsu_data_memory;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst        [NI];
  logic        req_valid  [NI];
  logic        req_ready  [NI];
  logic        req_we     [NI];
  logic [2:0]  req_funct3 [NI];
  logic [31:0] req_addr   [NI];
  logic [31:0] req_wdata  [NI];
  logic        rsp_valid  [NI];
  logic        rsp_ready  [NI];
  logic [31:0] rsp_rdata  [NI];
  logic        rsp_err    [NI];
  logic [1:0]  dbg        [NI];

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0]  mm     [NI][1024];
  bit          m_busy [NI];
  int          m_age  [NI];
  logic [31:0] m_rd   [NI];
  logic        m_err  [NI];

  always #5 clk = ~clk;

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, got, exp);
    end
  endtask

  // Architectural view: a request touches 1/2/4 little-endian bytes of a flat
  // byte array; loads extend by the signedness encoded in funct3[2].
  function automatic void model_access(input int i, input logic we, input logic [2:0] f3,
                                       input logic [31:0] a, input logic [31:0] wd,
                                       output logic err, output logic [31:0] rd);
    int nb;
    logic [31:0] v;
    err = 1'b0;
    rd  = '0;
    case (f3[1:0])
      2'd0:    nb = 1;
      2'd1:    nb = 2;
      2'd2:    nb = 4;
      default: nb = 0;
    endcase
    if (nb == 0 || (f3[2] && (we || nb == 4))) err = 1'b1;
    if (nb != 0 && (a % nb) != 0) err = 1'b1;
    if ((a / 4) >= 256) err = 1'b1;
    if (!err) begin
      if (we) begin
        for (int b = 0; b < nb; b++) mm[i][int'(a) + b] = wd[8*b +: 8];
      end else begin
        v = '0;
        for (int b = 0; b < nb; b++) v[8*b +: 8] = mm[i][int'(a) + b];
        if (!f3[2] && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
        rd = v;
      end
    end
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int L = (g == 0) ? 1 : ((g == 1) ? 3 : 4);

    lsu_data_memory #(.DEPTH(256), .LATENCY(L)) u_dut (
      .clk        (clk),
      .reset      (rst[g]),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_we     (req_we[g]),
      .req_funct3 (req_funct3[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .rsp_valid  (rsp_valid[g]),
      .rsp_ready  (rsp_ready[g]),
      .rsp_rdata  (rsp_rdata[g]),
      .rsp_err    (rsp_err[g]),
      .dbg_state  (dbg[g])
    );

    initial begin : model_and_compare
      logic e;
      logic [31:0] r;
      bit vis;
      m_busy[g] = 1'b0;
      m_age[g]  = 0;
      forever begin
        @(negedge clk);
        vis = m_busy[g] && (m_age[g] >= L - 1);
        chk($sformatf("inst%0d req_ready", g), req_ready[g], !m_busy[g]);
        chk($sformatf("inst%0d rsp_valid", g), rsp_valid[g], vis);
        if (vis) begin
          chk($sformatf("inst%0d rsp_rdata", g), rsp_rdata[g], m_rd[g]);
          chk($sformatf("inst%0d rsp_err", g), rsp_err[g], m_err[g]);
        end
        @(posedge clk or posedge rst[g]);
        if (rst[g]) begin
          m_busy[g] = 1'b0;
        end else if (m_busy[g]) begin
          if (m_age[g] >= L - 1 && rsp_ready[g]) m_busy[g] = 1'b0;
          else m_age[g]++;
        end else if (req_valid[g]) begin
          model_access(g, req_we[g], req_funct3[g], req_addr[g], req_wdata[g], e, r);
          m_busy[g] = 1'b1;
          m_age[g]  = 0;
          m_rd[g]   = r;
          m_err[g]  = e;
        end
      end
    end
  end

  task automatic do_req(input int i, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic err, output int lat);
    int n;
    @(negedge clk);
    req_valid[i]  = 1'b1;
    req_we[i]     = we;
    req_funct3[i] = f3;
    req_addr[i]   = a;
    req_wdata[i]  = wd;
    rsp_ready[i]  = 1'b1;
    n = 0;
    while (!req_ready[i] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait_bound", 32'(n < 50), 32'd1);
    @(posedge clk);
    #1 req_valid[i] = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid[i] && lat < 50);
    rd  = rsp_rdata[i];
    err = rsp_err[i];
    @(posedge clk);
    #1 rsp_ready[i] = 1'b0;
  endtask

  task automatic rq(input string name, input int i, input logic we, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] wd,
                    input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] rd;
    logic err;
    int lat;
    do_req(i, we, f3, a, wd, rd, err, lat);
    chk({name, " rdata"}, rd, exp_rd);
    chk({name, " err"}, 32'(err), 32'(exp_err));
    chk({name, " latency"}, lat, lat_of(i));
  endtask

  initial begin : global_bound
    #200000;
    n_fail++;
    $display("FAIL global_timeout: actual=timeout required=finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin : main
    int n;
    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b1; req_valid[i] = 1'b0; req_we[i] = 1'b0; req_funct3[i] = '0;
      req_addr[i] = '0; req_wdata[i] = '0; rsp_ready[i] = 1'b0;
    end
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("reset req_ready", 32'(req_ready[i]), 32'd1);
      chk("reset rsp_valid", 32'(rsp_valid[i]), 32'd0);
      chk("reset rsp_rdata", rsp_rdata[i], 32'd0);
      chk("reset rsp_err", 32'(rsp_err[i]), 32'd0);
    end
    @(negedge clk);
    #2 for (int i = 0; i < NI; i++) rst[i] = 1'b0;

    // LATENCY=1: word, byte and halfword accesses
    rq("sw_10",   0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    rq("lw_10",   0, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    rq("sb_12",   0, 1'b1, 3'b000, 32'h12, 32'h0000_0080, 32'h0, 1'b0);
    rq("lb_12",   0, 1'b0, 3'b000, 32'h12, 32'h0, 32'hFFFFFF80, 1'b0);
    rq("lbu_12",  0, 1'b0, 3'b100, 32'h12, 32'h0, 32'h00000080, 1'b0);
    rq("lw_10b",  0, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDE80BEEF, 1'b0);
    rq("lh_12",   0, 1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFDE80, 1'b0);
    rq("lhu_10",  0, 1'b0, 3'b101, 32'h10, 32'h0, 32'h0000BEEF, 1'b0);
    rq("lbu_13",  0, 1'b0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 1'b0);
    rq("sw_14",   0, 1'b1, 3'b010, 32'h14, 32'h12345678, 32'h0, 1'b0);
    rq("sh_16",   0, 1'b1, 3'b001, 32'h16, 32'hAAAA_8001, 32'h0, 1'b0);
    rq("lh_16",   0, 1'b0, 3'b001, 32'h16, 32'h0, 32'hFFFF8001, 1'b0);
    rq("lhu_16",  0, 1'b0, 3'b101, 32'h16, 32'h0, 32'h00008001, 1'b0);
    rq("lh_15",   0, 1'b0, 3'b001, 32'h15, 32'h0, 32'h0, 1'b1);
    rq("sh_15",   0, 1'b1, 3'b001, 32'h15, 32'hFFFFFFFF, 32'h0, 1'b1);
    rq("lw_14",   0, 1'b0, 3'b010, 32'h14, 32'h0, 32'h80015678, 1'b0);
    // range, alignment and funct3 errors
    rq("sw_0",    0, 1'b1, 3'b010, 32'h0, 32'h11223344, 32'h0, 1'b0);
    rq("sw_400",  0, 1'b1, 3'b010, 32'h400, 32'hFFFFFFFF, 32'h0, 1'b1);
    rq("lw_0",    0, 1'b0, 3'b010, 32'h0, 32'h0, 32'h11223344, 1'b0);
    rq("lw_400",  0, 1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 1'b1);
    rq("lw_hi",   0, 1'b0, 3'b010, 32'h8000_0010, 32'h0, 32'h0, 1'b1);
    rq("ld_f011", 0, 1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1'b1);
    rq("ld_f110", 0, 1'b0, 3'b110, 32'h0, 32'h0, 32'h0, 1'b1);
    rq("st_f100", 0, 1'b1, 3'b100, 32'h0, 32'h0, 32'h0, 1'b1);
    rq("lw_12",   0, 1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1);
    rq("lw_0b",   0, 1'b0, 3'b010, 32'h0, 32'h0, 32'h11223344, 1'b0);

    // LATENCY=3: first-valid timing, backpressure hold, request waiting during RESP
    rq("l3_sw_20", 1, 1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0);
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_funct3[1] = 3'b010;
    req_addr[1] = 32'h20; rsp_ready[1] = 1'b0;
    chk("l3 idle req_ready", 32'(req_ready[1]), 32'd1);
    @(posedge clk);
    #1 req_funct3[1] = 3'b100; req_addr[1] = 32'h21;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid[1] && n < 20);
    chk("l3 first valid cycle", n, 3);
    chk("l3 rdata", rsp_rdata[1], 32'hCAFEF00D);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("l3 hold valid", 32'(rsp_valid[1]), 32'd1);
      chk("l3 hold rdata", rsp_rdata[1], 32'hCAFEF00D);
      chk("l3 hold req_ready", 32'(req_ready[1]), 32'd0);
    end
    rsp_ready[1] = 1'b1;
    @(posedge clk);
    #1 rsp_ready[1] = 1'b0;
    @(negedge clk);
    chk("l3 ready after rsp", 32'(req_ready[1]), 32'd1);
    chk("l3 valid after rsp", 32'(rsp_valid[1]), 32'd0);
    @(posedge clk);
    #1 req_valid[1] = 1'b0; rsp_ready[1] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid[1] && n < 20);
    chk("l3 second valid cycle", n, 3);
    chk("l3 lbu_21", rsp_rdata[1], 32'h000000F0);
    @(posedge clk);
    #1 rsp_ready[1] = 1'b0;

    // LATENCY=4: reset while a load waits; earlier store survives
    rq("l4_sw_30", 2, 1'b1, 3'b010, 32'h30, 32'h0BADF00D, 32'h0, 1'b0);
    @(negedge clk);
    req_valid[2] = 1'b1; req_we[2] = 1'b0; req_funct3[2] = 3'b010;
    req_addr[2] = 32'h30; rsp_ready[2] = 1'b1;
    @(posedge clk);
    #1 req_valid[2] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("l4 waiting req_ready", 32'(req_ready[2]), 32'd0);
    #2 rst[2] = 1'b1;
    #1;
    chk("l4 reset rsp_valid", 32'(rsp_valid[2]), 32'd0);
    chk("l4 reset req_ready", 32'(req_ready[2]), 32'd1);
    @(negedge clk);
    #2 rst[2] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("l4 no late rsp", 32'(rsp_valid[2]), 32'd0);
    end
    rq("l4_lw_30", 2, 1'b0, 3'b010, 32'h30, 32'h0, 32'h0BADF00D, 1'b0);
    rq("l4_lb_33", 2, 1'b0, 3'b000, 32'h33, 32'h0, 32'h0000000B, 1'b0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_data_memory.md
Name: lsu_data_memory

Overview:
Parametrised successor to the core's word-only data memory. Adds RV32 sub-word loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) with byte lanes and sign/zero extension. Adds a configurable read latency behind a valid/ready request/response handshake, plus misalignment and range error reporting. Sits between the core's execute stage and data storage, replacing the combinational data-memory path.

Parameters:
DEPTH, 256, number of 32-bit words of storage (power of two, >=4)
LATENCY, 1, cycles from request acceptance to first rsp_valid (1..8)

Ports:
clk  input  1  clock, rising-edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request this cycle
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RV32 funct3 (size/sign)
req_addr  input  32  byte address
req_wdata  input  32  store data; low bytes used for SB/SH
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_rdata  output  32  extended load data; 0 for stores and errors
rsp_err  output  1  request was misaligned, out of range, or had an illegal funct3

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous and active-high, named reset.
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0. Storage array is not reset.
- FSM states:
  - IDLE: req_ready=1. On req_valid&&req_ready, latch the request. If LATENCY==1, go to RESP; otherwise go to WAIT with counter=LATENCY-1.
  - WAIT: req_ready=0. Counter decrements each cycle. When counter==1, the next state is RESP.
  - RESP: req_ready=0, rsp_valid=1, and rsp_rdata/rsp_err stay stable. On rsp_ready, go to IDLE.
- Timing: rsp_valid first rises exactly LATENCY cycles after the acceptance edge. Back-to-back throughput is one request per LATENCY+1 cycles with rsp_ready held high.
- Load data: sampled from storage at the acceptance edge. A store accepted later never alters an earlier load response.
- Store write: happens at the acceptance edge, only when no error is flagged. Only the addressed byte lanes change.
  - SB writes lane addr[1:0] with wdata[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0], little-endian.
  - SW writes all four lanes.
- Load extraction (little-endian):
  - LB/LH sign-extend to 32 bits.
  - LBU/LHU zero-extend.
  - LW is unchanged.
- Legal funct3 values:
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
  - Any other value sets rsp_err=1.
- Errors (rsp_err=1, rsp_rdata=0, no write):
  - Halfword with addr[0]=1.
  - Word with addr[1:0]!=0.
  - Word index addr[31:2] >= DEPTH.
  - Illegal funct3.
  - An error response still follows the full LATENCY timing.
- Store response: rsp_rdata=0, rsp_err=0 on success.
- Backpressure: with rsp_ready=0 the block stays in RESP indefinitely, outputs held, and no new request is accepted.
- Simultaneous events: a request presented while in RESP is not accepted on the same edge that rsp_ready completes the response. It is accepted on the next IDLE cycle.
- Reset mid-operation: return to IDLE immediately and drop the pending response (rsp_valid=0). A store already written at acceptance remains in storage.
- Address bits above log2(DEPTH)+1 are used only for the range check, never wrapped.

Test Plan:
1. LATENCY=1: SW 0xDEADBEEF @0x10, then LW @0x10 -> store response err=0. Load rsp_valid one cycle after accept, rdata=0xDEADBEEF.
2. After case 1: SB 0x80 @0x12, then LB @0x12 -> 0xFFFFFF80. LBU @0x12 -> 0x00000080. LW @0x10 -> 0xDE80BEEF.
3. SH 0x8001 @0x16, then LH @0x16 -> 0xFFFF8001. LHU @0x16 -> 0x00008001. LH @0x15 -> err=1, rdata=0, storage unchanged.
4. LATENCY=3: LW accepted at edge k -> rsp_valid high from edge k+3. Holding rsp_ready=0 for 5 cycles keeps rsp_valid/rdata stable and req_ready=0. After rsp_ready=1, req_ready=1 the next cycle.
5. DEPTH=256: SW @0x400 -> err=1, no write. Load funct3=011 -> err=1.
6. LATENCY=4: assert reset two cycles after accepting an LW -> rsp_valid=0, req_ready=1 immediately, and no response appears afterwards.
